ctrl_seq: RTL

//  Sequencing control decoder for the basic processor; successor to the single-cycle combinational decoder.

---
 rtl/ctrl_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: sequencing control decoder.
// Decodes the instruction word into datapath / fetch controls and adds a
// run-state FSM (idle, run, multi-cycle load wait, sticky halt) plus a
// saturating active-cycle counter.
module ctrl_seq #(
  parameter int         INSTR_W    = 9,
  parameter int         TSEL_W     = 2,
  parameter int         MEM_LAT    = 2,
  parameter logic [2:0] JUMP_FUNCT = 3'b100,
  parameter int         CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instruction,
  output logic               Jump,
  output logic               BranchEn,
  output logic               RegWrEn,
  output logic               MemWrEn,
  output logic               LoadInst,
  output logic               StoreInst,
  output logic               Ack,
  output logic [TSEL_W-1:0]  TargSel,
  output logic               StallPC,
  output logic [CNT_W-1:0]   CycleCnt
);

  // A zero-latency load never enters LOAD_WAIT; keep a 1-bit counter so the
  // declaration stays legal in that configuration.
  localparam int WC_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LOAD = (MEM_LAT > 0) ? WC_W'(MEM_LAT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LOAD_WAIT,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]        op3;
  logic [3:0]        op4;
  logic              dec_store, dec_load, dec_halt, dec_branch, dec_jump, dec_regwr;
  logic [TSEL_W-1:0] dec_tsel;

  // Pure instruction decode, independent of run state
  always_comb begin
    op3        = Instruction[INSTR_W-1 -: 3];
    op4        = Instruction[INSTR_W-1 -: 4];
    dec_store  = (op3 == 3'b110);
    dec_load   = (op3 == 3'b011);
    dec_halt   = &Instruction;
    dec_branch = &Instruction[3:0];
    dec_jump   = (Instruction[2:0] == JUMP_FUNCT);
    dec_regwr  = (op4 <= 4'b0110) || ((op4 >= 4'b1000) && (op4 <= 4'b1101));
    dec_tsel   = Instruction[TSEL_W+1:2];
  end

  // Output gating by run state, next-state, wait counter and cycle counter
  always_comb begin
    Jump      = 1'b0;
    BranchEn  = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    LoadInst  = 1'b0;
    StoreInst = 1'b0;
    Ack       = 1'b0;
    TargSel   = '0;
    StallPC   = 1'b1;
    state_d   = state_q;
    wc_d      = wc_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (dec_halt) begin
          Ack     = 1'b1;
          state_d = S_HALT;
        end else if (dec_load) begin
          LoadInst = 1'b1;
          TargSel  = dec_tsel;
          if (MEM_LAT > 0) begin
            wc_d    = WC_LOAD;
            state_d = S_LOAD_WAIT;
          end else begin
            RegWrEn = 1'b1;
            StallPC = 1'b0;
          end
        end else begin
          // A store never writes the register file even when op4 is in the
          // register-writing range.
          Jump      = dec_jump;
          BranchEn  = dec_branch;
          RegWrEn   = dec_regwr & ~dec_store;
          MemWrEn   = dec_store;
          StoreInst = dec_store;
          TargSel   = dec_tsel;
          StallPC   = 1'b0;
        end
      end
      S_LOAD_WAIT: begin
        LoadInst = 1'b1;
        TargSel  = dec_tsel;
        if (wc_q != '0) begin
          wc_d = wc_q - 1'b1;
        end else begin
          RegWrEn = 1'b1;
          StallPC = 1'b0;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        Ack = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (((state_q == S_RUN) || (state_q == S_LOAD_WAIT)) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // State, wait counter and cycle counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CycleCnt = cnt_q;

endmodule
